// File: rtl/ram8_fifo_ctrl.sv
// FIFO controller around an external RAM8: one RAM op per cycle (read priority) plus a registered output stage.
// Optional fall-through path from wr_data to rd_data when the RAM is empty: define RAM8_FIFO_BYPASS_EN.
module ram8_fifo_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_out,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_READ,
        OP_WRITE,
        OP_BYPASS
    } op_t;

    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [ADDR_W:0]   r_memCnt;
    logic [DATA_W-1:0] r_rdData;
    logic              r_rdValid;

    logic w_outFree;
    logic w_memEmpty;
    logic w_memFull;
    logic w_bypassOk;
    op_t  w_op;

    assign w_outFree  = !r_rdValid || rd_ready;
    assign w_memEmpty = (r_memCnt == '0);
    assign w_memFull  = (r_memCnt == DEPTH);

`ifdef RAM8_FIFO_BYPASS_EN
    assign w_bypassOk = w_memEmpty && w_outFree && wr_valid;
`else
    assign w_bypassOk = 1'b0;
`endif

    // Read has priority on the single RAM port so the output stage never starves.
    always_comb begin
        w_op = OP_IDLE;
        if (w_outFree && !w_memEmpty) begin
            w_op = OP_READ;
        end else if (w_bypassOk) begin
            w_op = OP_BYPASS;
        end else if (wr_valid && !w_memFull) begin
            w_op = OP_WRITE;
        end
    end

    assign wr_ready    = (w_op != OP_READ) && !w_memFull;
    assign ram_in      = wr_data;
    assign ram_load    = (w_op == OP_WRITE) && reset_n;
    assign ram_address = (w_op == OP_WRITE) ? r_wrPtr : r_rdPtr;
    assign rd_data     = r_rdData;
    assign rd_valid    = r_rdValid;
    assign count       = r_memCnt + {{ADDR_W{1'b0}}, r_rdValid};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_memCnt  <= '0;
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
        end else begin
            case (w_op)
                OP_READ: begin
                    r_rdData  <= ram_out;
                    r_rdValid <= 1'b1;
                    r_rdPtr   <= r_rdPtr + PTR_ONE;
                    r_memCnt  <= r_memCnt - CNT_ONE;
                end
                OP_BYPASS: begin
                    r_rdData  <= wr_data;
                    r_rdValid <= 1'b1;
                end
                OP_WRITE: begin
                    r_wrPtr  <= r_wrPtr + PTR_ONE;
                    r_memCnt <= r_memCnt + CNT_ONE;
                    if (r_rdValid && rd_ready) begin
                        r_rdValid <= 1'b0;
                    end
                end
                default: begin
                    if (r_rdValid && rd_ready) begin
                        r_rdValid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram8_fifo_ctrl.sv
// Directed self-checking bench for ram8_fifo_ctrl with a behavioural RAM8 attached.
// Define RAM8_FIFO_BYPASS_EN for both files to also exercise the fall-through path.
module tb_ram8_fifo_ctrl;

    logic        clock;
    logic        reset_n;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [2:0]  ram_address;
    logic [15:0] ram_out;
    logic [3:0]  count;

    logic [15:0] ramMem [8];
    int checks;
    int failures;

    ram8_fifo_ctrl #(.DATA_W(16), .ADDR_W(3)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .wr_data(wr_data),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .ram_in(ram_in),
        .ram_load(ram_load),
        .ram_address(ram_address),
        .ram_out(ram_out),
        .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural RAM8: combinational read, write on the rising edge when load is high.
    always @(posedge clock) begin
        if (ram_load) ramMem[ram_address] <= ram_in;
    end
    assign ram_out = ramMem[ram_address];

    task automatic applyReset();
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic pushWord(input logic [15:0] data, input int maxCycles, output bit accepted);
        wr_valid = 1'b1;
        wr_data  = data;
        accepted = 1'b0;
        for (int k = 0; k < maxCycles && !accepted; k++) begin
            #1;
            if (wr_ready) accepted = 1'b1;
            @(posedge clock);
            #1;
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        bit acc;
        bit seen;
        applyReset();
        checks++;
        if (rd_valid !== 1'b0 || count !== 4'd0 || rd_data !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_state: rd_valid=%b count=%0d rd_data=%h expected 0 0 0000", rd_valid, count, rd_data);
        end
        for (int i = 0; i < 5; i++) begin
            pushWord(16'h0010 + 16'(i), 4, acc);
            checks++;
            if (acc !== 1'b1) begin
                failures++;
                $display("[TB] FAIL reset_prefill_accept[%0d]: accepted=%b expected 1", i, acc);
            end
        end
        checks++;
        if (count !== 4'd5) begin
            failures++;
            $display("[TB] FAIL reset_prefill_count: count=%0d expected 5", count);
        end
        wr_valid = 1'b1;
        wr_data  = 16'h5555;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || count !== 4'd0 || ram_load !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_midstream: rd_valid=%b count=%0d ram_load=%b expected 0 0 0", rd_valid, count, ram_load);
        end
        wr_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        rd_ready = 1'b1;
        pushWord(16'h0001, 4, acc);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (rd_valid) seen = 1'b1;
            else begin
                @(posedge clock);
                #1;
            end
        end
        checks++;
        if (seen !== 1'b1 || rd_data !== 16'h0001) begin
            failures++;
            $display("[TB] FAIL reset_after_push: rd_valid_seen=%b rd_data=%h expected 1 0001", seen, rd_data);
        end
        @(posedge clock);
        #1;
        rd_ready = 1'b0;
    endtask

    task automatic test_latency();
        applyReset();
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 16'h1111;
        #1;
        checks++;
`ifdef RAM8_FIFO_BYPASS_EN
        if (ram_load !== 1'b0 || wr_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lat_cycle0: ram_load=%b wr_ready=%b expected 0 1", ram_load, wr_ready);
        end
        @(posedge clock);
        #1;
        wr_valid = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h1111 || count !== 4'd1) begin
            failures++;
            $display("[TB] FAIL lat_bypass: rd_valid=%b rd_data=%h count=%0d expected 1 1111 1", rd_valid, rd_data, count);
        end
`else
        if (ram_load !== 1'b1 || ram_address !== 3'd0 || wr_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lat_cycle0: ram_load=%b addr=%0d wr_ready=%b expected 1 0 1", ram_load, ram_address, wr_ready);
        end
        @(posedge clock);
        #1;
        wr_valid = 1'b0;
        #1;
        checks++;
        if (ram_load !== 1'b0 || ram_address !== 3'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b0 || count !== 4'd1) begin
            failures++;
            $display("[TB] FAIL lat_cycle1: ram_load=%b addr=%0d rd_valid=%b wr_ready=%b count=%0d expected 0 0 0 0 1",
                     ram_load, ram_address, rd_valid, wr_ready, count);
        end
        @(posedge clock);
        #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h1111 || count !== 4'd1) begin
            failures++;
            $display("[TB] FAIL lat_cycle2: rd_valid=%b rd_data=%h count=%0d expected 1 1111 1", rd_valid, rd_data, count);
        end
`endif
    endtask

    task automatic test_fill();
        bit acc;
        applyReset();
        rd_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            pushWord(16'hA000 + 16'(i), 4, acc);
            checks++;
            if (acc !== 1'b1) begin
                failures++;
                $display("[TB] FAIL fill_accept[%0d]: accepted=%b expected 1", i, acc);
            end
        end
        #1;
        checks++;
        if (count !== 4'd9 || wr_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fill_full: count=%0d wr_ready=%b expected 9 0", count, wr_ready);
        end
        wr_valid = 1'b1;
        wr_data  = 16'hA009;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (ram_load !== 1'b0 || wr_ready !== 1'b0 || count !== 4'd9) begin
                failures++;
                $display("[TB] FAIL fill_overflow[%0d]: ram_load=%b wr_ready=%b count=%0d expected 0 0 9", k, ram_load, wr_ready, count);
            end
            @(posedge clock);
            #1;
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_drain();
        rd_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 16'hA000 + 16'(i)) begin
                failures++;
                $display("[TB] FAIL drain[%0d]: rd_valid=%b rd_data=%h expected 1 %h", i, rd_valid, rd_data, 16'hA000 + 16'(i));
            end
            @(posedge clock);
            #1;
        end
        checks++;
        if (rd_valid !== 1'b0 || count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL drain_empty: rd_valid=%b count=%0d expected 0 0", rd_valid, count);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int pushIdx;
        int popIdx;
        int cycle;
        bit pushFire;
        bit popFire;
        logic [15:0] popData;
        applyReset();
        pushIdx = 0;
        popIdx  = 0;
        cycle   = 0;
        while (popIdx < 20 && cycle < 400) begin
            wr_valid = (pushIdx < 20);
            wr_data  = 16'h0100 + 16'(pushIdx);
            rd_ready = (cycle % 2 == 0);
            #1;
            pushFire = wr_valid && wr_ready;
            popFire  = rd_valid && rd_ready;
            popData  = rd_data;
            @(posedge clock);
            #1;
            if (pushFire) pushIdx++;
            if (popFire) begin
                checks++;
                if (popData !== 16'h0100 + 16'(popIdx)) begin
                    failures++;
                    $display("[TB] FAIL stream_pop[%0d]: rd_data=%h expected %h", popIdx, popData, 16'h0100 + 16'(popIdx));
                end
                popIdx++;
            end
            cycle++;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        #1;
        checks++;
        if (popIdx !== 20 || count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL stream_total: popped=%0d count=%0d expected 20 0", popIdx, count);
        end
    endtask

`ifdef RAM8_FIFO_BYPASS_EN
    task automatic test_bypass();
        bit sawLoad;
        applyReset();
        sawLoad  = 1'b0;
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 16'hBEEF;
        #1;
        if (ram_load) sawLoad = 1'b1;
        @(posedge clock);
        #1;
        wr_valid = 1'b0;
        #1;
        if (ram_load) sawLoad = 1'b1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF || sawLoad !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bypass: rd_valid=%b rd_data=%h ram_load_seen=%b expected 1 beef 0", rd_valid, rd_data, sawLoad);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) ramMem[i] = '0;
        test_reset();
        test_latency();
        test_fill();
        test_drain();
        test_back_to_back();
`ifdef RAM8_FIFO_BYPASS_EN
        test_bypass();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
